// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with a single-entry valid/ready
// output buffer and a sticky overrun flag.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                     CLK,
    input  logic                     Clear,
    input  logic                     ser_in,
    input  logic                     ser_valid,
    input  logic                     lsb_first,
    input  logic                     frame,
    output logic [WIDTH-1:0]         D_par,
    output logic                     D_valid,
    input  logic                     D_ready,
    output logic                     overrun,
    input  logic                     clr_ovr,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ord_q, ord_d;
    logic             val_q, val_d;
    logic             ovr_q, ovr_d;

    logic [CW-1:0]    eff_cnt;
    logic             first;
    logic             ord_eff;
    logic             complete;
    logic             buf_free;

    always_comb begin
        asm_d    = asm_q;
        par_d    = par_q;
        cnt_d    = cnt_q;
        ord_d    = ord_q;
        val_d    = val_q;
        ovr_d    = ovr_q;
        complete = 1'b0;

        // frame restarts the word: the accepted bit (if any) is bit 0
        eff_cnt  = frame ? '0 : cnt_q;
        first    = (eff_cnt == '0);
        ord_eff  = first ? lsb_first : ord_q;
        buf_free = !val_q || D_ready;

        if (frame) begin
            cnt_d = '0;
        end

        if (ser_valid) begin
            ord_d = ord_eff;
            asm_d = ord_eff ? {ser_in, asm_q[WIDTH-1:1]}
                            : {asm_q[WIDTH-2:0], ser_in};
            if (eff_cnt == LAST) begin
                complete = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = eff_cnt + 1'b1;
            end
        end

        if (val_q && D_ready) begin
            val_d = 1'b0;
        end

        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        if (complete) begin
            if (buf_free) begin
                par_d = asm_d;
                val_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            asm_q <= '0;
            par_q <= '0;
            cnt_q <= '0;
            ord_q <= 1'b0;
            val_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            par_q <= par_d;
            cnt_q <= cnt_d;
            ord_q <= ord_d;
            val_q <= val_d;
            ovr_q <= ovr_d;
        end
    end

    assign D_par   = par_q;
    assign D_valid = val_q;
    assign overrun = ovr_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomised and directed bench for serial_word_receiver against a
// bit-list reference model.
module tb_serial_word_receiver;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         Clear = 1'b0;
    logic         ser_in = 1'b0;
    logic         ser_valid = 1'b0;
    logic         lsb_first = 1'b0;
    logic         frame = 1'b0;
    logic         D_ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic [W-1:0] D_par;
    logic         D_valid;
    logic         overrun;
    logic [1:0]   bit_cnt;

    int n_vec = 0;
    int n_err = 0;

    int           m_bits[$];
    bit           m_ord;
    logic [W-1:0] m_par;
    bit           m_val;
    bit           m_ovr;

    serial_word_receiver #(.WIDTH(W)) dut (
        .CLK(CLK),
        .Clear(Clear),
        .ser_in(ser_in),
        .ser_valid(ser_valid),
        .lsb_first(lsb_first),
        .frame(frame),
        .D_par(D_par),
        .D_valid(D_valid),
        .D_ready(D_ready),
        .overrun(overrun),
        .clr_ovr(clr_ovr),
        .bit_cnt(bit_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_ord = 1'b0;
        m_par = '0;
        m_val = 1'b0;
        m_ovr = 1'b0;
    endtask

    // Word value from the received bit list and its bit order
    function automatic logic [W-1:0] build(input bit ord);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (ord) w[i] = m_bits[i][0];
            else     w[W-1-i] = m_bits[i][0];
        end
        return w;
    endfunction

    task automatic model_step();
        bit           done;
        logic [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (frame) m_bits.delete();
        if (ser_valid) begin
            if (m_bits.size() == 0) m_ord = lsb_first;
            m_bits.push_back(int'(ser_in));
            if (m_bits.size() == W) begin
                word = build(m_ord);
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (clr_ovr) m_ovr = 1'b0;
        if (done) begin
            if (!m_val || D_ready) begin
                m_par = word;
                m_val = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_val && D_ready) begin
            m_val = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".par"}, 32'(D_par), 32'(m_par));
        check({tag, ".val"}, 32'(D_valid), 32'(m_val));
        check({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
        check({tag, ".cnt"}, 32'(bit_cnt), 32'(m_bits.size()));
    endtask

    task automatic cyc(input string tag, input logic sv, input logic si,
                       input logic lf, input logic fr, input logic rdy,
                       input logic clr);
        ser_valid = sv;
        ser_in    = si;
        lsb_first = lf;
        frame     = fr;
        D_ready   = rdy;
        clr_ovr   = clr;
        @(posedge CLK);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic send4(input string tag, input logic [3:0] b,
                         input logic lf, input logic rdy);
        for (int i = 3; i >= 0; i--) begin
            cyc(tag, 1'b1, b[i], lf, 1'b0, rdy, 1'b0);
        end
    endtask

    task automatic async_clear(input string tag);
        #3;
        Clear = 1'b1;
        #1;
        model_reset();
        check({tag, ".par"}, 32'(D_par), 32'h0);
        check({tag, ".val"}, 32'(D_valid), 32'h0);
        check({tag, ".ovr"}, 32'(overrun), 32'h0);
        check({tag, ".cnt"}, 32'(bit_cnt), 32'h0);
        #1;
        Clear = 1'b0;
    endtask

    initial begin
        model_reset();
        Clear = 1'b1;
        #12;
        check_all("reset");
        Clear = 1'b0;

        send4("msb", 4'b1011, 1'b0, 1'b0);
        check("msb_word", 32'(D_par), 32'hB);
        check("msb_valid", 32'(D_valid), 32'h1);
        cyc("drain1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        cyc("lsb", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lsb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lsb", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("lsb", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lsb_word", 32'(D_par), 32'hD);
        cyc("drain2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send4("ovr_a", 4'b1011, 1'b0, 1'b0);
        send4("ovr_b", 4'b0110, 1'b0, 1'b0);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_hold", 32'(D_par), 32'hB);
        cyc("clr_ovr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", 32'(overrun), 32'h0);
        cyc("drain3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        send4("b2b_a", 4'b1011, 1'b0, 1'b1);
        send4("b2b_b", 4'b0110, 1'b0, 1'b1);
        check("b2b_word", 32'(D_par), 32'h6);
        cyc("drain4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        cyc("frm", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("frm", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("frm", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("frm_cnt", 32'(bit_cnt), 32'h1);
        cyc("frm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc("gap", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        cyc("frm", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("frm", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("frm_word", 32'(D_par), 32'h1);
        cyc("frm0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        send4("clr_a", 4'b1011, 1'b0, 1'b0);
        cyc("clr_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("clr_b", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        async_clear("aclr");
        send4("post", 4'b0101, 1'b0, 1'b0);
        check("post_word", 32'(D_par), 32'h5);

        for (int n = 0; n < 3000; n++) begin
            cyc("rnd",
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 15) == 0),
                logic'($urandom_range(0, 2) != 0),
                logic'($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 299) == 0) async_clear("rnd_aclr");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Serial-to-parallel receiver that reassembles WIDTH-bit words from a 1-bit serial stream produced by the team's universal shift register in shift-left or shift-right mode. Bits are collected in an internal shift register under a bit counter. Each completed word moves into a single-entry output buffer with a valid/ready handshake. A sticky overrun flag reports words lost because the consumer stalled.

## Interface
- WIDTH, 4, word length in bits (≥2)
- CLK  input  1  rising-edge clock
- Clear  input  1  asynchronous active-high reset
- ser_in  input  1  serial data bit
- ser_valid  input  1  ser_in is sampled on this edge when high
- lsb_first  input  1  bit order (0: first bit → MSB; 1: first bit → bit 0); sampled with bit 0 of each word, held for that word
- frame  input  1  word-boundary sync; restarts word assembly
- D_par  output  WIDTH  received word (output buffer)
- D_valid  output  1  D_par holds an unconsumed word
- D_ready  input  1  consumer accepts D_par when D_valid=1
- overrun  output  1  sticky: a completed word was dropped
- clr_ovr  input  1  synchronous clear of overrun
- bit_cnt  output  clog2(WIDTH)  bits collected in current partial word

## Operation
- States: IDLE (bit_cnt=0, no partial word) and COLLECT (0<bit_cnt<WIDTH). Output buffer: EMPTY/FULL, tracked by D_valid.
- Accept bit: on an edge with ser_valid=1, ser_in enters the assembly register:
  - lsb_first=0: shift left, ser_in into bit 0.
  - lsb_first=1: shift right, ser_in into bit WIDTH-1.
  - bit_cnt increments.
- The order latched at bit 0 governs the whole word. A lsb_first change mid-word is ignored until the next word.
- frame=1 with ser_valid=1: the partial word is discarded. ser_in becomes bit 0 of a new word and bit_cnt=1. lsb_first is re-sampled.
- frame=1 with ser_valid=0: the partial word is discarded and bit_cnt=0 (IDLE).
- Word completion: the edge accepting the bit with bit_cnt=WIDTH-1 completes the word. On that edge:
  - bit_cnt wraps to 0.
  - The assembled word, including this bit, is the completed word.
- Buffer free on a completion edge means D_valid=0, or D_valid=1 and D_ready=1 (simultaneous consume and refill is allowed, with no bubble).
  - Free: D_par takes the completed word and D_valid=1.
  - Not free: the completed word is dropped, D_par/D_valid are unchanged, and overrun is set to 1.
- Handshake: D_valid=1 and D_ready=1 on an edge transfers the word. D_valid falls unless a refill happens on the same edge. D_par is stable while D_valid=1 and D_ready=0.
- overrun stays set until clr_ovr=1 or Clear. If clr_ovr coincides with a new overrun event, overrun ends set (set wins).
- D_ready is ignored when D_valid=0.

## Timing
- Reset values (Clear=1, asynchronous, immediate):
  - D_par=0, D_valid=0, overrun=0, bit_cnt=0.
  - Assembly register=0; latched order=0.
- A Clear asserted mid-word discards the partial word and any buffered word. Clear has priority over all inputs.
- Latency: D_valid rises immediately after the edge accepting the last bit. Minimum is WIDTH edges from the first bit.
- Back-to-back: with D_ready held at 1, one word per WIDTH valid bits is sustained with no lost bits.
- ser_valid gaps pause assembly. bit_cnt and the partial word are held.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then bits 1,0,1,1 with lsb_first=0 and D_ready=0 → D_valid=1 after 4th edge, D_par=4'b1011, bit_cnt=0.
- Same bits with lsb_first=1 → D_par=4'b1101. Toggling lsb_first after bit 0 → word still 4'b1101.
- Word 4'b1011 held (D_ready=0), then second word 0,1,1,0 completes → overrun=1, D_par stays 4'b1011. Then clr_ovr=1 → overrun=0.
- D_ready=1 constantly, with a stream 1,0,1,1,0,1,1,0 → two words 4'b1011 then 4'b0110, D_valid high for one cycle each, overrun=0.
- Bits 1,1 then frame=1 with ser_valid=1 and ser_in=0, followed by 0,0,1 → D_par=4'b0001 and the partial word is discarded. Also cover ser_valid gaps of 3 idle cycles mid-word → same result.
- Clear pulsed asynchronously between edges after 2 bits with D_valid=1 → all outputs 0 immediately. The next 4 bits 0,1,0,1 → D_par=4'b0101.
